// File: rtl/universal_shift_reg_if.sv
// Purpose : bundles the control/data inputs and the register outputs of
//           universal_shift_reg so the block connects through one port.
// Ports   : en, mode, serial_in, parallel_in (and rotate when USR_ROTATE_EN
//           is defined) go into the register; q, serial_out_left,
//           serial_out_right, shift_cnt and frame_done come out of it.
//           master = the side driving the controls, slave = the register.
interface universal_shift_reg_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             en;
    logic [1:0]       mode;
    logic             serial_in;
    logic [WIDTH-1:0] parallel_in;
`ifdef USR_ROTATE_EN
    logic             rotate;
`endif
    logic [WIDTH-1:0] q;
    logic             serial_out_left;
    logic             serial_out_right;
    logic [CNT_W-1:0] shift_cnt;
    logic             frame_done;

`ifdef USR_ROTATE_EN
    modport master (
        output en, mode, serial_in, parallel_in, rotate,
        input  q, serial_out_left, serial_out_right, shift_cnt, frame_done
    );
    modport slave (
        input  en, mode, serial_in, parallel_in, rotate,
        output q, serial_out_left, serial_out_right, shift_cnt, frame_done
    );
`else
    modport master (
        output en, mode, serial_in, parallel_in,
        input  q, serial_out_left, serial_out_right, shift_cnt, frame_done
    );
    modport slave (
        input  en, mode, serial_in, parallel_in,
        output q, serial_out_left, serial_out_right, shift_cnt, frame_done
    );
`endif
endinterface

// File: rtl/universal_shift_reg.sv
// Purpose : WIDTH-bit universal shift register (hold / shift left / shift
//           right / parallel load) with clock enable, both serial outputs and
//           a frame counter that pulses frame_done after WIDTH same-direction
//           shifts.
// Latency : 1 cycle from inputs to q; serial outputs are wiring of q.
// Flow    : no backpressure; en=0 freezes all state for that edge.
// Ports   : clk, rst (async active-high), bus (slave modport): en, mode,
//           serial_in, parallel_in -> q, serial_out_left, serial_out_right,
//           shift_cnt, frame_done.
// Option  : define USR_ROTATE_EN to add bus.rotate; when set in a shift mode
//           the bit leaving the register re-enters at the other end.
module universal_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    universal_shift_reg_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_r,        q_nxt;
    logic [CNT_W-1:0] cnt_r,      cnt_nxt;
    logic             last_dir_r, last_dir_nxt;
    logic             dir_vld_r,  dir_vld_nxt;
    logic             done_r,     done_nxt;

    // Bits entering on a left / right shift: serial_in, or the wrapped-around
    // end bit while rotating.
    logic left_in;
    logic right_in;

`ifdef USR_ROTATE_EN
    assign left_in  = bus.rotate ? q_r[WIDTH-1] : bus.serial_in;
    assign right_in = bus.rotate ? q_r[0]       : bus.serial_in;
`else
    assign left_in  = bus.serial_in;
    assign right_in = bus.serial_in;
`endif

    always_comb begin
        logic shifting;
        logic dir;

        q_nxt        = q_r;
        cnt_nxt      = cnt_r;
        last_dir_nxt = last_dir_r;
        dir_vld_nxt  = dir_vld_r;
        done_nxt     = 1'b0;
        shifting     = 1'b0;
        dir          = DIR_LEFT;

        if (bus.en) begin
            case (bus.mode)
                MODE_HOLD: begin
                end
                MODE_LEFT: begin
                    q_nxt    = {q_r[WIDTH-2:0], left_in};
                    shifting = 1'b1;
                    dir      = DIR_LEFT;
                end
                MODE_RIGHT: begin
                    q_nxt    = {right_in, q_r[WIDTH-1:1]};
                    shifting = 1'b1;
                    dir      = DIR_RIGHT;
                end
                MODE_LOAD: begin
                    // A load starts a fresh frame; the next shift counts as 1
                    // whatever its direction.
                    q_nxt       = bus.parallel_in;
                    cnt_nxt     = '0;
                    dir_vld_nxt = 1'b0;
                end
                default: begin
                end
            endcase

            if (shifting) begin
                if (!dir_vld_r || (dir != last_dir_r)) begin
                    // First shift of a frame, or a direction change: any
                    // partial frame is dropped without a pulse.
                    cnt_nxt      = CNT_W'(1);
                    last_dir_nxt = dir;
                    dir_vld_nxt  = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    // WIDTH-th shift: pulse while q holds the full frame and
                    // wrap so the next frame follows with no idle cycle.
                    cnt_nxt  = '0;
                    done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r        <= '0;
            cnt_r      <= '0;
            last_dir_r <= DIR_LEFT;
            dir_vld_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            q_r        <= q_nxt;
            cnt_r      <= cnt_nxt;
            last_dir_r <= last_dir_nxt;
            dir_vld_r  <= dir_vld_nxt;
            done_r     <= done_nxt;
        end
    end

    assign bus.q                = q_r;
    assign bus.serial_out_left  = q_r[WIDTH-1];
    assign bus.serial_out_right = q_r[0];
    assign bus.shift_cnt        = cnt_r;
    assign bus.frame_done       = done_r;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Purpose : directed, table-driven bench for universal_shift_reg at WIDTH=4,
//           with hand-written sequences for asynchronous reset and rotation.
// Ports   : drives the master side of universal_shift_reg_if.
module tb_universal_shift_reg;
    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic clk;
    logic rst;

    universal_shift_reg_if #(.WIDTH(WIDTH)) bus ();

    universal_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag, input logic [WIDTH-1:0] eq,
                               input logic [CNT_W-1:0] ecnt, input logic efd);
        check({tag, " q"},   64'(bus.q), 64'(eq));
        check({tag, " cnt"}, 64'(bus.shift_cnt), 64'(ecnt));
        check({tag, " fd"},  64'(bus.frame_done), 64'(efd));
        check({tag, " sol"}, 64'(bus.serial_out_left), 64'(eq[WIDTH-1]));
        check({tag, " sor"}, 64'(bus.serial_out_right), 64'(eq[0]));
    endtask

    typedef struct {
        logic             en;
        logic [1:0]       mode;
        logic             sin;
        logic [WIDTH-1:0] pin;
        logic [WIDTH-1:0] exp_q;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_fd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic [1:0] mode, input logic sin,
                                input logic [WIDTH-1:0] pin, input logic [WIDTH-1:0] eq,
                                input logic [CNT_W-1:0] ecnt, input logic efd);
        vec_t v;
        v.en = en; v.mode = mode; v.sin = sin; v.pin = pin;
        v.exp_q = eq; v.exp_cnt = ecnt; v.exp_fd = efd;
        return v;
    endfunction

    task automatic drive(input logic en, input logic [1:0] mode, input logic sin,
                         input logic [WIDTH-1:0] pin);
        bus.en          = en;
        bus.mode        = mode;
        bus.serial_in   = sin;
        bus.parallel_in = pin;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Left-shift frame 1,0,1,1 then hold
        vecs.push_back(mk(1, 2'b01, 1, 4'h0, 4'b0001, 3'd1, 0));
        vecs.push_back(mk(1, 2'b01, 0, 4'h0, 4'b0010, 3'd2, 0));
        vecs.push_back(mk(1, 2'b01, 1, 4'h0, 4'b0101, 3'd3, 0));
        vecs.push_back(mk(1, 2'b01, 1, 4'h0, 4'b1011, 3'd0, 1));
        vecs.push_back(mk(1, 2'b00, 0, 4'h0, 4'b1011, 3'd0, 0));
        // Load 1001 then four right shifts with serial_in=0
        vecs.push_back(mk(1, 2'b11, 0, 4'b1001, 4'b1001, 3'd0, 0));
        vecs.push_back(mk(1, 2'b10, 0, 4'h0, 4'b0100, 3'd1, 0));
        vecs.push_back(mk(1, 2'b10, 0, 4'h0, 4'b0010, 3'd2, 0));
        vecs.push_back(mk(1, 2'b10, 0, 4'h0, 4'b0001, 3'd3, 0));
        vecs.push_back(mk(1, 2'b10, 0, 4'h0, 4'b0000, 3'd0, 1));
        // Enable gating: two lefts, three disabled cycles, two lefts
        vecs.push_back(mk(1, 2'b01, 1, 4'h0, 4'b0001, 3'd1, 0));
        vecs.push_back(mk(1, 2'b01, 1, 4'h0, 4'b0011, 3'd2, 0));
        vecs.push_back(mk(0, 2'b01, 0, 4'h0, 4'b0011, 3'd2, 0));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b0011, 3'd2, 0));
        vecs.push_back(mk(0, 2'b01, 0, 4'h0, 4'b0011, 3'd2, 0));
        vecs.push_back(mk(1, 2'b01, 0, 4'h0, 4'b0110, 3'd3, 0));
        vecs.push_back(mk(1, 2'b01, 1, 4'h0, 4'b1101, 3'd0, 1));
        vecs.push_back(mk(0, 2'b01, 1, 4'h0, 4'b1101, 3'd0, 0));
        // Direction change: two lefts, then four rights
        vecs.push_back(mk(1, 2'b01, 0, 4'h0, 4'b1010, 3'd1, 0));
        vecs.push_back(mk(1, 2'b01, 0, 4'h0, 4'b0100, 3'd2, 0));
        vecs.push_back(mk(1, 2'b10, 1, 4'h0, 4'b1010, 3'd1, 0));
        vecs.push_back(mk(1, 2'b10, 0, 4'h0, 4'b0101, 3'd2, 0));
        vecs.push_back(mk(1, 2'b10, 1, 4'h0, 4'b1010, 3'd3, 0));
        vecs.push_back(mk(1, 2'b10, 0, 4'h0, 4'b0101, 3'd0, 1));
        vecs.push_back(mk(1, 2'b00, 1, 4'h0, 4'b0101, 3'd0, 0));
        // Load mid-frame restarts counting at 1 even in the same direction
        vecs.push_back(mk(1, 2'b10, 0, 4'h0, 4'b0010, 3'd1, 0));
        vecs.push_back(mk(1, 2'b11, 0, 4'b1111, 4'b1111, 3'd0, 0));
        vecs.push_back(mk(1, 2'b10, 0, 4'h0, 4'b0111, 3'd1, 0));

        drive(0, 2'b00, 0, '0);
`ifdef USR_ROTATE_EN
        bus.rotate = 1'b0;
`endif
        rst = 1'b1;
        #1;
        check_state("reset", 4'b0000, 3'd0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].mode, vecs[i].sin, vecs[i].pin);
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_fd);
        end

        // Asynchronous reset mid-frame with q=1011, shift_cnt=3
        drive(1, 2'b11, 0, 4'b0001);
        @(posedge clk); #1;
        drive(1, 2'b01, 0, '0);
        @(posedge clk); #1;
        drive(1, 2'b01, 1, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_state("pre_rst", 4'b1011, 3'd3, 0);
        #3;
        rst = 1'b1;
        #1;
        check_state("async_rst", 4'b0000, 3'd0, 0);
        @(posedge clk); #1;
        check_state("rst_held", 4'b0000, 3'd0, 0);
        rst = 1'b0;
        drive(1, 2'b01, 1, '0);
        @(posedge clk); #1;
        check_state("post_rst", 4'b0001, 3'd1, 0);

`ifdef USR_ROTATE_EN
        // Left rotation of 1000; serial_in held at 1 must be ignored
        bus.rotate = 1'b1;
        drive(1, 2'b11, 1, 4'b1000);
        @(posedge clk); #1;
        check_state("rot_load", 4'b1000, 3'd0, 0);
        drive(1, 2'b01, 1, '0);
        @(posedge clk); #1;
        check_state("rotl1", 4'b0001, 3'd1, 0);
        @(posedge clk); #1;
        check_state("rotl2", 4'b0010, 3'd2, 0);
        @(posedge clk); #1;
        check_state("rotl3", 4'b0100, 3'd3, 0);
        @(posedge clk); #1;
        check_state("rotl4", 4'b1000, 3'd0, 1);
        // Right rotation with serial_in=0
        drive(1, 2'b10, 0, '0);
        @(posedge clk); #1;
        check_state("rotr1", 4'b0100, 3'd1, 0);
        bus.rotate = 1'b0;
        drive(1, 2'b10, 1, '0);
        @(posedge clk); #1;
        check_state("shr_after_rot", 4'b1010, 3'd2, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
